// File: rtl/stage1_multiway_prequeue_if.sv
`default_nettype none
// ============================================================================
// Interface : stage1_multiway_prequeue_if
// Purpose   : Enqueue/dequeue/flush bundle for the stage-1 pre-decode queue.
// Revision  : 1.0
// ============================================================================
interface stage1_multiway_prequeue_if #(
    parameter int WAYS      = 2,
    parameter int TOTAL_IN  = 16,
    parameter int TOTAL_OUT = 24,
    parameter int BID_W     = 3,
    parameter int CNT_W     = 4
);
    logic [WAYS-1:0]           in_valid;
    logic [WAYS*TOTAL_IN-1:0]  in_instr;
    logic                      in_ready;
    logic [WAYS-1:0]           out_valid;
    logic [WAYS*TOTAL_OUT-1:0] out_entry;
    logic [WAYS-1:0]           out_ready;
    logic                      flush_valid;
    logic [BID_W-1:0]          flush_bid;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;

    modport master (
        output in_valid, in_instr, out_ready, flush_valid, flush_bid,
        input  in_ready, out_valid, out_entry, count, full, empty
    );

    modport slave (
        input  in_valid, in_instr, out_ready, flush_valid, flush_bid,
        output in_ready, out_valid, out_entry, count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/stage1_multiway_prequeue.sv
`default_nettype none
// ============================================================================
// Module   : stage1_multiway_prequeue
// Purpose  : WAYS-wide pre-decoding circular FIFO with branch-id flush.
// Revision : 1.0
// ============================================================================
module stage1_multiway_prequeue #(
    parameter int               WAYS   = 2,
    parameter int               DEPTH  = 8,
    parameter int               OPC_W  = 4,
    parameter int               DES_W  = 4,
    parameter int               SRC1_W = 4,
    parameter int               SRC2_W = 4,
    parameter int               IMM_W  = 4,
    parameter int               BID_W  = 3,
    parameter logic [OPC_W-1:0] BR_OPC = 4'hC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stage1_multiway_prequeue_if.slave q
);
    localparam int TOTAL_IN  = OPC_W + DES_W + SRC1_W + SRC2_W;
    localparam int TOTAL_OUT = TOTAL_IN + BID_W + 1 + IMM_W;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int EXT_W     = (IMM_W > SRC2_W) ? IMM_W : SRC2_W;

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BID_W-1:0]     br_ctr_q, br_ctr_d, br_run;
    logic [TOTAL_OUT-1:0] mem_q [DEPTH];
    logic [TOTAL_OUT-1:0] entry_d [WAYS];
    logic [TOTAL_IN-1:0]  lane_instr;
    logic [EXT_W-1:0]     src2_ext;
    logic                 lane_br;
    logic                 in_ready;
    logic [CNT_W-1:0]     n_in, n_out;
    logic                 deq_run;
    logic                 hit;
    logic [CNT_W-1:0]     hit_off;
    logic [PTR_W-1:0]     scan_idx;
    logic [WAYS-1:0]      in_valid_inc;

    // Ready looks only at registered occupancy, so a full queue refuses input
    // even in a cycle where it also dequeues.
    assign in_ready   = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(WAYS)) && !q.flush_valid;
    assign q.in_ready = in_ready;
    assign q.count    = count_q;
    assign q.full     = (count_q == CNT_W'(DEPTH));
    assign q.empty    = (count_q == '0);

    // Pre-decode; br_run carries the branch id across lanes in program order.
    always_comb begin
        br_run     = br_ctr_q;
        lane_instr = '0;
        src2_ext   = '0;
        lane_br    = 1'b0;
        n_in       = '0;
        for (int k = 0; k < WAYS; k++) begin
            lane_instr = q.in_instr[k*TOTAL_IN +: TOTAL_IN];
            lane_br    = (lane_instr[TOTAL_IN-1 -: OPC_W] == BR_OPC);
            src2_ext   = EXT_W'(lane_instr[SRC2_W-1:0]);
            entry_d[k] = {lane_instr, br_run, lane_br, src2_ext[IMM_W-1:0]};
            if (q.in_valid[k]) begin
                n_in = n_in + CNT_W'(1);
                if (lane_br) begin
                    br_run = br_run + BID_W'(1);
                end
            end
        end
        if (!in_ready) begin
            n_in = '0;
        end
    end

    // Out lanes; only the leading run of valid&ready lanes retires.
    always_comb begin
        n_out       = '0;
        deq_run     = !q.flush_valid;
        q.out_valid = '0;
        q.out_entry = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (int'(count_q) > k) begin
                q.out_valid[k]                        = !q.flush_valid;
                q.out_entry[k*TOTAL_OUT +: TOTAL_OUT] = mem_q[head_q + PTR_W'(k)];
            end
            deq_run = deq_run && (int'(count_q) > k) && q.out_ready[k];
            if (deq_run) begin
                n_out = n_out + CNT_W'(1);
            end
        end
    end

    // Scan youngest-to-oldest so the oldest matching branch wins.
    always_comb begin
        hit      = 1'b0;
        hit_off  = '0;
        scan_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = head_q + PTR_W'(i);
            if ((int'(count_q) > i) && mem_q[scan_idx][IMM_W] &&
                (mem_q[scan_idx][IMM_W+1 +: BID_W] == q.flush_bid)) begin
                hit     = 1'b1;
                hit_off = CNT_W'(i);
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        br_ctr_d = br_ctr_q;
        if (q.flush_valid) begin
            br_ctr_d = q.flush_bid + BID_W'(1);
            if (hit) begin
                tail_d  = head_q + PTR_W'(hit_off) + PTR_W'(1);
                count_d = hit_off + CNT_W'(1);
            end else begin
                tail_d  = head_q;
                count_d = '0;
            end
        end else begin
            head_d  = head_q + PTR_W'(n_out);
            tail_d  = tail_q + PTR_W'(n_in);
            count_d = count_q + n_in - n_out;
            if (in_ready) begin
                br_ctr_d = br_run;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            br_ctr_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            br_ctr_q <= br_ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready) begin
            for (int k = 0; k < WAYS; k++) begin
                if (q.in_valid[k]) begin
                    mem_q[tail_q + PTR_W'(k)] <= entry_d[k];
                end
            end
        end
    end

    // Lane valids must be a contiguous run starting at lane 0.
    assign in_valid_inc = q.in_valid + WAYS'(1);
    a_in_valid_contig: assert property (@(posedge clk) disable iff (!rst_n)
        ((q.in_valid & in_valid_inc) == '0));

endmodule
`default_nettype wire

// File: tb/tb_stage1_multiway_prequeue.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage1_multiway_prequeue
// Purpose  : Self-checking bench: queue-model scoreboard plus vector table.
// Revision : 1.0
// ============================================================================
module tb_stage1_multiway_prequeue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [23:0] mq[$];
    logic [2:0]  mbr;
    logic        got_rdy;

    typedef struct {
        logic [1:0] iv;
        logic [1:0] ordy;
        logic       rdy;
        int         cnt;
    } vec_t;
    vec_t tbl[12];

    stage1_multiway_prequeue_if #(.WAYS(2), .TOTAL_IN(16), .TOTAL_OUT(24),
                                  .BID_W(3), .CNT_W(4)) bus ();

    stage1_multiway_prequeue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] predec(input logic [15:0] ins, input logic [2:0] bid);
        return {ins, bid, (ins[15:12] == 4'hC), ins[3:0]};
    endfunction

    function automatic logic [31:0] rnd_ins();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 2) == 0) a[15:12] = 4'hC;
        if ($urandom_range(0, 2) == 0) b[15:12] = 4'hC;
        return {b, a};
    endfunction

    function automatic logic [1:0] rnd_mask();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
    endfunction

    task automatic idle();
        bus.in_valid    = 2'b00;
        bus.in_instr    = '0;
        bus.out_ready   = 2'b00;
        bus.flush_valid = 1'b0;
        bus.flush_bid   = '0;
    endtask

    // One clock: drive, check against the model, advance the model, return after the edge.
    task automatic cycle(input logic [1:0] iv, input logic [31:0] ins, input logic [1:0] ordy,
                         input logic fv, input logic [2:0] fb, output logic rdy_seen);
        int          sz;
        int          nout;
        int          hit;
        logic        erdy;
        logic [23:0] e;
        @(negedge clk);
        bus.in_valid    = iv;
        bus.in_instr    = ins;
        bus.out_ready   = ordy;
        bus.flush_valid = fv;
        bus.flush_bid   = fb;
        #1;
        sz       = mq.size();
        erdy     = ((8 - sz) >= 2) && !fv;
        rdy_seen = bus.in_ready;
        chk("count", 32'(bus.count), 32'(sz));
        chk("full", 32'(bus.full), 32'(sz == 8));
        chk("empty", 32'(bus.empty), 32'(sz == 0));
        chk("in_ready", 32'(bus.in_ready), 32'(erdy));
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", 32'(bus.out_valid[k]), 32'((sz > k) && !fv));
            if (sz > k) chk("out_entry", 32'(bus.out_entry[k*24 +: 24]), 32'(mq[k]));
        end
        if (fv) begin
            hit = -1;
            for (int i = 0; i < sz; i++)
                if (hit < 0 && mq[i][4] && mq[i][7:5] == fb) hit = i;
            if (hit >= 0) begin
                while (mq.size() > hit + 1) void'(mq.pop_back());
            end else begin
                mq.delete();
            end
            mbr = fb + 3'd1;
        end else begin
            nout = 0;
            while (nout < 2 && nout < sz && ordy[nout]) nout++;
            for (int k = 0; k < nout; k++) e = mq.pop_front();
            if (erdy) begin
                for (int k = 0; k < 2; k++) begin
                    if (iv[k]) begin
                        e = predec(ins[k*16 +: 16], mbr);
                        mq.push_back(e);
                        if (e[4]) mbr = mbr + 3'd1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mbr    = '0;
        tbl[0]  = '{2'b11, 2'b00, 1'b1, 2};
        tbl[1]  = '{2'b11, 2'b00, 1'b1, 4};
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 6};
        tbl[3]  = '{2'b11, 2'b00, 1'b1, 8};
        tbl[4]  = '{2'b11, 2'b01, 1'b0, 7};
        tbl[5]  = '{2'b11, 2'b00, 1'b0, 7};
        tbl[6]  = '{2'b00, 2'b11, 1'b0, 5};
        tbl[7]  = '{2'b01, 2'b11, 1'b1, 4};
        tbl[8]  = '{2'b11, 2'b01, 1'b1, 5};
        tbl[9]  = '{2'b11, 2'b11, 1'b1, 5};
        tbl[10] = '{2'b11, 2'b00, 1'b1, 7};
        tbl[11] = '{2'b00, 2'b01, 1'b0, 6};

        // Reset state
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_entry", 32'(bus.out_entry[23:0]), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Pre-decode and one-cycle latency
        cycle(2'b11, {16'hC567, 16'h1234}, 2'b00, 1'b0, 3'd0, got_rdy);
        chk("t2_lane0", 32'(bus.out_entry[23:0]), 32'h123404);
        chk("t2_lane1", 32'(bus.out_entry[47:24]), 32'hC56717);
        cycle(2'b01, {16'h0000, 16'hC0A1}, 2'b11, 1'b0, 3'd0, got_rdy);
        chk("t2_next_bid", 32'(bus.out_entry[23:0]), 32'hC0A131);
        cycle(2'b00, 32'h0, 2'b01, 1'b0, 3'd0, got_rdy);
        chk("t2_drained", 32'(bus.empty), 32'd1);

        // Fill to full, full+dequeue, partial traffic
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, rnd_ins(), tbl[i].ordy, 1'b0, 3'd0, got_rdy);
            chk("tbl_in_ready", 32'(got_rdy), 32'(tbl[i].rdy));
            chk("tbl_count", 32'(bus.count), 32'(tbl[i].cnt));
        end

        // Mixed traffic with wrap; order checked by the scoreboard
        for (int i = 0; i < 20; i++) begin
            cycle(rnd_mask(), rnd_ins(), rnd_mask(), ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)), got_rdy);
        end
        repeat (5) cycle(2'b00, 32'h0, 2'b11, 1'b0, 3'd0, got_rdy);
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Flush miss
        cycle(2'b11, {16'h2222, 16'h1111}, 2'b00, 1'b0, 3'd0, got_rdy);
        cycle(2'b00, 32'h0, 2'b00, 1'b1, 3'd5, got_rdy);
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_empty", 32'(bus.empty), 32'd1);
        cycle(2'b11, {16'h3333, 16'hC0A9}, 2'b00, 1'b0, 3'd0, got_rdy);
        chk("t5_bid6", 32'(bus.out_entry[23:0]), 32'hC0A9D9);
        cycle(2'b00, 32'h0, 2'b00, 1'b1, 3'd1, got_rdy);
        chk("t5b_empty", 32'(bus.empty), 32'd1);

        // Flush hit keeps the branch and everything older
        cycle(2'b11, {16'hC0B2, 16'h1AAA}, 2'b00, 1'b0, 3'd0, got_rdy);
        cycle(2'b11, {16'h3CCC, 16'h2BBB}, 2'b00, 1'b0, 3'd0, got_rdy);
        cycle(2'b00, 32'h0, 2'b00, 1'b1, 3'd2, got_rdy);
        chk("t4_count", 32'(bus.count), 32'd2);
        chk("t4_lane0", 32'(bus.out_entry[23:0]), 32'h1AAA4A);
        chk("t4_lane1", 32'(bus.out_entry[47:24]), 32'hC0B252);
        cycle(2'b01, {16'h0000, 16'hC0C3}, 2'b00, 1'b0, 3'd0, got_rdy);
        cycle(2'b00, 32'h0, 2'b11, 1'b0, 3'd0, got_rdy);
        chk("t4_bid3", 32'(bus.out_entry[23:0]), 32'hC0C373);
        chk("t4_count2", 32'(bus.count), 32'd1);

        // Flush wins over same-cycle enqueue and dequeue
        cycle(2'b11, {16'h4444, 16'h5555}, 2'b11, 1'b1, 3'd3, got_rdy);
        chk("t6_no_write", 32'(got_rdy), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd1);
        chk("t6_lane0", 32'(bus.out_entry[23:0]), 32'hC0C373);

        // Asynchronous reset mid-stream
        cycle(2'b11, {16'h6666, 16'h7777}, 2'b00, 1'b0, 3'd0, got_rdy);
        cycle(2'b11, {16'h8888, 16'h9999}, 2'b00, 1'b0, 3'd0, got_rdy);
        chk("t1_pre_count", 32'(bus.count), 32'd5);
        @(negedge clk);
        bus.in_valid = 2'b11;
        rst_n        = 1'b0;
        #1;
        chk("t1_count", 32'(bus.count), 32'd0);
        chk("t1_empty", 32'(bus.empty), 32'd1);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
        mq.delete();
        mbr = '0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(2'b11, {16'h1234, 16'hC001}, 2'b00, 1'b0, 3'd0, got_rdy);
        chk("t1_bid0", 32'(bus.out_entry[23:0]), 32'hC00111);
        cycle(2'b00, 32'h0, 2'b11, 1'b0, 3'd0, got_rdy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
